// File: rtl/l1_trig_conditioner.sv
// ============================================================================
// Module   : l1_trig_conditioner
// Purpose  : Per-channel L1 trigger gating, pulse shaping with holdoff and
//            saturating strobe-latched scalers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module l1_trig_conditioner #(
   parameter int NCH = 20,
   parameter int SCW = 16,
   parameter int WW  = 4,
   parameter int HW  = 8
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [NCH-1:0]     trig_i,
   input  logic [NCH-1:0]     pwr_i,
   input  logic [NCH-1:0]     mask_i,
   input  logic [WW-1:0]      width_i,
   input  logic [HW-1:0]      holdoff_i,
   input  logic               sce_i,
   output logic [NCH-1:0]     trig_o,
   output logic [NCH*SCW-1:0] scaler_o,
   output logic [NCH-1:0]     overflow_o,
   output logic               scaler_valid_o
);

   localparam int CW = (WW > HW) ? WW : HW;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_FIRE = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   logic [NCH-1:0] r_trig_q;
   logic [NCH-1:0] w_qual;
   logic [CW-1:0]  w_width_load;

   // Presetting to ones keeps a level already high at reset release from firing.
   always_ff @(posedge clk_i) begin
      if (rst_i) r_trig_q <= '1;
      else       r_trig_q <= trig_i;
   end

   assign w_qual       = trig_i & ~r_trig_q & pwr_i & ~mask_i;
   assign w_width_load = (width_i == '0) ? '0 : (CW'(width_i) - CW'(1));

   always_ff @(posedge clk_i) begin
      if (rst_i) scaler_valid_o <= 1'b0;
      else       scaler_valid_o <= sce_i;
   end

   for (genvar c = 0; c < NCH; c++) begin : g_ch
      state_t         r_state, w_state_nxt;
      logic [CW-1:0]  r_cnt, w_cnt_nxt;
      logic [HW-1:0]  r_hold, w_hold_nxt;
      logic           r_fire;
      logic           w_live, w_free, w_accept;
      logic [SCW-1:0] r_run, r_lat;
      logic           r_sat, r_ovf;

      assign w_live = pwr_i[c] & ~mask_i[c];

      // The terminal edge of FIRE (no holdoff) or HOLD may accept a new rise.
      always_comb begin
         w_state_nxt = r_state;
         w_cnt_nxt   = r_cnt;
         w_hold_nxt  = r_hold;
         w_free      = 1'b0;
         w_accept    = 1'b0;
         case (r_state)
            S_IDLE: w_free = 1'b1;
            S_FIRE: begin
               if (!w_live) begin
                  w_state_nxt = S_IDLE;
               end else if (r_cnt == '0) begin
                  if (r_hold == '0) begin
                     w_state_nxt = S_IDLE;
                     w_free      = 1'b1;
                  end else begin
                     w_state_nxt = S_HOLD;
                     w_cnt_nxt   = CW'(r_hold) - CW'(1);
                  end
               end else begin
                  w_cnt_nxt = r_cnt - CW'(1);
               end
            end
            S_HOLD: begin
               if (!w_live) begin
                  w_state_nxt = S_IDLE;
               end else if (r_cnt == '0) begin
                  w_state_nxt = S_IDLE;
                  w_free      = 1'b1;
               end else begin
                  w_cnt_nxt = r_cnt - CW'(1);
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
         if (w_free && w_qual[c]) begin
            w_accept    = 1'b1;
            w_state_nxt = S_FIRE;
            w_cnt_nxt   = w_width_load;
            w_hold_nxt  = holdoff_i;
         end
      end

      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_hold  <= '0;
            r_fire  <= 1'b0;
         end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_hold  <= w_hold_nxt;
            r_fire  <= (w_state_nxt == S_FIRE);
         end
      end

      // A trigger accepted on the strobe edge opens the new period with a count of 1.
      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            r_run <= '0;
            r_sat <= 1'b0;
            r_lat <= '0;
            r_ovf <= 1'b0;
         end else if (sce_i) begin
            r_lat <= r_run;
            r_ovf <= r_sat;
            r_run <= w_accept ? SCW'(1) : '0;
            r_sat <= 1'b0;
         end else if (w_accept) begin
            if (r_run == '1) r_sat <= 1'b1;
            else             r_run <= r_run + SCW'(1);
         end
      end

      assign trig_o[c]              = r_fire;
      assign scaler_o[c*SCW +: SCW] = r_lat;
      assign overflow_o[c]          = r_ovf;
   end

endmodule

`default_nettype wire

// File: tb/tb_l1_trig_conditioner.sv
// ============================================================================
// Module   : tb_l1_trig_conditioner
// Purpose  : Randomised self-checking bench against an event-time model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_l1_trig_conditioner;

   localparam int NCH  = 20;
   localparam int SCW  = 4;
   localparam int WW   = 4;
   localparam int HW   = 8;
   localparam int NCYC = 6000;

   logic               clk_i = 1'b0;
   logic               rst_i;
   logic [NCH-1:0]     trig_i, pwr_i, mask_i;
   logic [WW-1:0]      width_i;
   logic [HW-1:0]      holdoff_i;
   logic               sce_i;
   logic [NCH-1:0]     trig_o;
   logic [NCH*SCW-1:0] scaler_o;
   logic [NCH-1:0]     overflow_o;
   logic               scaler_valid_o;

   int n_checks = 0;
   int n_errors = 0;

   // Model state, in absolute edge numbers rather than FSM states.
   int n_edge = 0;
   int fire_end [NCH];
   int ok_from  [NCH];
   bit prev     [NCH];
   int run_cnt  [NCH];
   bit sat      [NCH];
   int lat      [NCH];
   bit ovf      [NCH];
   bit valid_exp;

   l1_trig_conditioner #(.NCH(NCH), .SCW(SCW), .WW(WW), .HW(HW)) u_dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .trig_i         (trig_i),
      .pwr_i          (pwr_i),
      .mask_i         (mask_i),
      .width_i        (width_i),
      .holdoff_i      (holdoff_i),
      .sce_i          (sce_i),
      .trig_o         (trig_o),
      .scaler_o       (scaler_o),
      .overflow_o     (overflow_o),
      .scaler_valid_o (scaler_valid_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check_val(input string tag, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s @edge %0d: got %0h expected %0h", tag, n_edge, act, exp);
      end
   endtask

   task automatic model_edge();
      int  w, h;
      bit  live, qual, acc;
      n_edge++;
      if (rst_i) begin
         for (int c = 0; c < NCH; c++) begin
            fire_end[c] = 0;
            ok_from[c]  = n_edge + 1;
            prev[c]     = 1'b1;
            run_cnt[c]  = 0;
            sat[c]      = 1'b0;
            lat[c]      = 0;
            ovf[c]      = 1'b0;
         end
         valid_exp = 1'b0;
         return;
      end
      w = (width_i == 0) ? 1 : int'(width_i);
      h = int'(holdoff_i);
      for (int c = 0; c < NCH; c++) begin
         live = pwr_i[c] && !mask_i[c];
         qual = trig_i[c] && !prev[c] && live;
         if (n_edge < ok_from[c] && !live) begin
            fire_end[c] = n_edge;
            ok_from[c]  = n_edge;
         end
         acc = qual && (n_edge >= ok_from[c]);
         if (acc) begin
            fire_end[c] = n_edge + w;
            ok_from[c]  = n_edge + w + h;
         end
         if (sce_i) begin
            lat[c]     = run_cnt[c];
            ovf[c]     = sat[c];
            run_cnt[c] = acc ? 1 : 0;
            sat[c]     = 1'b0;
         end else if (acc) begin
            if (run_cnt[c] == (1 << SCW) - 1) sat[c] = 1'b1;
            else                              run_cnt[c]++;
         end
         prev[c] = trig_i[c];
      end
      valid_exp = sce_i;
   endtask

   task automatic compare_outputs();
      logic [NCH-1:0]     e_trig, e_ovf;
      logic [NCH*SCW-1:0] e_sc;
      for (int c = 0; c < NCH; c++) begin
         e_trig[c]            = (n_edge < fire_end[c]);
         e_ovf[c]             = ovf[c];
         e_sc[c*SCW +: SCW]   = SCW'(lat[c]);
      end
      check_val("trig_o",         256'(trig_o),         256'(e_trig));
      check_val("scaler_o",       256'(scaler_o),       256'(e_sc));
      check_val("overflow_o",     256'(overflow_o),     256'(e_ovf));
      check_val("scaler_valid_o", 256'(scaler_valid_o), 256'(valid_exp));
   endtask

   initial begin
      int sce_rate;
      rst_i     = 1'b1;
      trig_i    = '1;
      pwr_i     = '1;
      mask_i    = '0;
      width_i   = WW'(2);
      holdoff_i = '0;
      sce_i     = 1'b0;
      for (int cyc = 0; cyc < NCYC; cyc++) begin
         @(posedge clk_i);
         model_edge();
         @(negedge clk_i);
         compare_outputs();

         sce_rate = (cyc / 1000) % 3 == 0 ? 3 : ((cyc / 1000) % 3 == 1 ? 30 : 200);
         if (cyc < 3) begin
            rst_i = 1'b1;
         end else if (cyc < 8) begin
            rst_i = 1'b0;   // inputs stay high across release
         end else begin
            rst_i = ($urandom_range(499) == 0);
            for (int c = 0; c < NCH; c++) begin
               if ($urandom_range(2) == 0) trig_i[c] = ~trig_i[c];
               pwr_i[c]  = ($urandom_range(19) != 0);
               mask_i[c] = ($urandom_range(24) == 0);
            end
            if ($urandom_range(15) == 0) width_i = WW'($urandom_range(15));
            if ($urandom_range(15) == 0)
               holdoff_i = ($urandom_range(3) == 0) ? HW'($urandom_range(40)) : HW'($urandom_range(4));
            sce_i = ($urandom_range(sce_rate) == 0);
         end
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/l1_trig_conditioner.md
# l1_trig_conditioner

Parametrised per-channel L1 trigger conditioner that succeeds the fixed 20-channel daughterboard trigger/scaler map. It sits between the daughterboard trigger inputs and the RF trigger tree. For each of NCH channels it:
- gates the raw trigger with daughter power and the L1 mask,
- converts rising edges into programmable-width output pulses with a retrigger holdoff,
- counts accepted triggers in saturating scalers, latched on a strobe.

## Interface

Parameters:
- NCH, 20, number of trigger channels
- SCW, 16, scaler width in bits
- WW, 4, width of pulse-width field
- HW, 8, width of holdoff field

Ports:
- clk_i  in  1  trigger clock; all logic on its rising edge
- rst_i  in  1  synchronous reset, active-high
- trig_i  in  NCH  raw channel triggers, already synchronous to clk_i
- pwr_i  in  NCH  1 = channel's daughterboard powered
- mask_i  in  NCH  1 = channel masked (L1 mask)
- width_i  in  WW  output pulse width in cycles; 0 is treated as 1
- holdoff_i  in  HW  dead cycles after pulse end; 0 means no holdoff
- sce_i  in  1  scaler latch/clear strobe, one cycle
- trig_o  out  NCH  conditioned trigger pulses, registered
- scaler_o  out  NCH*SCW  latched counts; channel c occupies bits [c*SCW +: SCW]
- overflow_o  out  NCH  latched saturation flags, one per channel
- scaler_valid_o  out  1  one-cycle pulse when scaler_o/overflow_o update

## Operation

Per-channel front end:
- trig_q <= trig_i each edge.
- rise = trig_i & ~trig_q.
- qual = rise & pwr_i & ~mask_i.

Per-channel state machine (IDLE, FIRE, HOLD) with counter cnt:
- **IDLE:**
  - On qual: go to FIRE, cnt <= max(width_i,1)-1.
  - width_i and holdoff_i are captured at this edge. Later changes do not affect the pulse in flight.
- **FIRE:**
  - trig_o = 1.
  - If cnt == 0: go to HOLD with cnt <= captured holdoff-1, or go directly to IDLE if captured holdoff == 0.
  - Otherwise cnt decrements.
- **HOLD:**
  - trig_o = 0.
  - If cnt == 0: go to IDLE. Otherwise cnt decrements.
- Rising edges in FIRE or HOLD are ignored and not counted.
- If pwr_i falls or mask_i rises while in FIRE or HOLD, the channel goes to IDLE at the next edge and trig_o drops. The already-counted trigger stays counted.

Scalers:
- Each channel's running counter increments on every IDLE->FIRE transition.
- The counter saturates at 2^SCW-1. Any accepted trigger while saturated sets a sticky sat bit.
- On sce_i, at the same edge:
  - scaler_o <= running counts, overflow_o <= sat bits, scaler_valid_o <= 1.
  - Running counters reset to 0 and sat bits clear.
  - A trigger accepted at the same edge as sce_i goes into the new period: the counter loads 1.
- scaler_o and overflow_o hold their values between strobes. Back-to-back sce_i is legal; each strobe latches one period.

Reset (rst_i high at an edge):
- All FSMs go to IDLE.
- trig_o, scaler_o, overflow_o, scaler_valid_o, running counters and sat bits go to 0.
- trig_q is set to all ones, so an input already high at reset release does not fire. It must go low, then high.
- Reset mid-pulse truncates the pulse at that edge.

## Timing

- Latency: trig_i goes high before edge k (and was low at edge k-1) -> trig_o high after edge k.
- Pulse length: W = max(width_i,1). trig_o is high for exactly W cycles and low after edge k+W.
- Holdoff: H = holdoff_i. The earliest next accepted rise is sampled at edge k+W+H.
  - H=0: a rise sampled at k+W is accepted, giving a minimum 1-cycle low gap because the edge detector requires a low sample.
- scaler_valid_o is high for the cycle after the sce_i edge. scaler_o is valid from that same cycle.
- No combinational path from any input to any output.

## Test plan

- Power and masking: NCH=20, width=2, holdoff=0, pwr_i=0xFFFFF, mask_i=0.
  - Pulse trig_i[3:0]=0xF for 1 cycle at edge 10 -> trig_o[3:0] high during cycles 10-11.
  - sce_i at edge 20 -> counts 1,1,1,1 on channels 0-3, 0 elsewhere; scaler_valid_o high 1 cycle.
- Pulse width and holdoff: width=5, holdoff=3.
  - trig_i[7] toggles every 2 cycles for 40 cycles -> trig_o[7] high 5 of every 8 cycles -> count 5.
- Power/mask gating:
  - pwr_i[4]=0 or mask_i[4]=1 -> no trig_o[4], count 0.
  - Deassert pwr_i[5] at cycle 2 of a width=8 pulse -> trig_o[5] low at the next edge, count 1.
- Saturation: SCW=4, 20 accepted triggers -> scaler 15, overflow_o[c]=1.
  - The following sce_i with no new triggers -> scaler 0, overflow 0.
- Same-edge trigger and strobe: trigger accepted at the same edge as sce_i -> latched value excludes it; next period reports 1.
- Reset behaviour:
  - trig_i[0] held high across rst_i -> no pulse until it falls and rises again.
  - rst_i during FIRE -> trig_o 0 and scaler_o 0 at the next edge.
